ram_dump_reader: RTL and testbench

Dual-port 64x32 block RAM with a sequential dump engine. The user write port is identical to the team's single-port RAM write port. On a start pulse, the engine reads every word from address 0 to DEPTH-1 and streams the words out over a valid/ready interface. It is the read-back counterpart to file-initialized RAM: it pulls contents out so they can be checked or exported.

---
 rtl/ram_dump_pkg.sv | 12 +
 rtl/ram_dump_skid.sv | 42 ++++
 rtl/ram_dump_reader.sv | 137 +++++++++++++
 tb/tb_ram_dump_reader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ram_dump_pkg.sv
// ram_dump_pkg: shared types and default sizing for the RAM dump reader.
//   state_t    : dump engine FSM states
//   DEF_*      : default word width, address width and depth
//   LAST_ADDR  : final address of a default-sized dump
package ram_dump_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
  localparam int LAST_ADDR  = DEF_DEPTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, CKSUM, FIN} state_t;
endpackage

// File: rtl/ram_dump_skid.sv
// ram_dump_skid: 2-entry valid/ready FIFO between the RAM read port and the
// output stream.
//   push/push_data : beat arriving from the registered RAM read
//   pop            : beat accepted downstream (only asserted while valid)
//   valid/head     : oldest stored beat, held stable until popped
//   free           : number of empty slots, used to throttle read issue
module ram_dump_skid #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   free
);
  logic [1:0][W-1:0] mem;
  logic              wptr, rptr;
  logic [1:0]        cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = mem[rptr];
  assign free  = 2'd2 - cnt;
endmodule

// File: rtl/ram_dump_reader.sv
// ram_dump_reader: DEPTH x DATA_W RAM with a user write port and a dump
// engine that streams every word (address 0..DEPTH-1) over valid/ready.
//   clk, rst_n            : clock, async active-low reset (RAM not reset)
//   we, addr, din         : user write port, active at all times
//   start                 : one-cycle dump request, honoured only when idle
//   busy, done            : engine active / one-cycle completion pulse
//   m_valid, m_ready      : stream handshake
//   m_data, m_addr, m_last: streamed word, its address, final-beat marker
// Optional feature: RAM_DUMP_CHECKSUM_EN appends a sum-of-words beat
// (m_addr=0, m_last=1) after the last data beat.
module ram_dump_reader
  import ram_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last
);
  localparam int                BW   = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] ram [DEPTH];
  state_t            state, state_nx;

  // One extra bit so the terminal count DEPTH is visible.
  logic [ADDR_W:0]   rd_cnt;
  logic              rd_vld, issue, sk_valid, sk_pop, final_pop, push_last;
  logic [DATA_W-1:0] rd_data, sk_data;
  logic [ADDR_W-1:0] rd_addr_q, sk_addr;
  logic              sk_last;
  logic [BW-1:0]     sk_head;
  logic [1:0]        sk_free;

  // Read-first: a same-cycle write to the read address is not seen.
  always_ff @(posedge clk) begin
    if (we)    ram[addr] <= din;
    if (issue) rd_data   <= ram[rd_cnt[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= 1'b0;
      rd_addr_q <= '0;
      rd_cnt    <= '0;
    end else begin
      rd_vld <= issue;
      if (issue) rd_addr_q <= rd_cnt[ADDR_W-1:0];
      if (state == IDLE && start) rd_cnt <= '0;
      else if (issue)             rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Issue only when the beat in flight plus stored beats, less the one
  // leaving this cycle, still leaves a slot: keeps one beat per cycle
  // with m_ready high and never overflows when it drops.
  assign issue = (state == RUN) && !rd_cnt[ADDR_W] &&
                 ({1'b0, sk_free} + {2'b0, sk_pop} > {2'b0, rd_vld});

`ifdef RAM_DUMP_CHECKSUM_EN
  assign push_last = 1'b0;
`else
  assign push_last = (rd_addr_q == LAST);
`endif

  ram_dump_skid #(.W(BW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_vld),
    .push_data({push_last, rd_addr_q, rd_data}),
    .pop      (sk_pop),
    .valid    (sk_valid),
    .head     (sk_head),
    .free     (sk_free)
  );

  assign {sk_last, sk_addr, sk_data} = sk_head;
  assign sk_pop    = sk_valid && m_ready;
  // Addresses leave in order, so popping LAST after all issues is final.
  assign final_pop = sk_pop && rd_cnt[ADDR_W] && (sk_addr == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
`ifdef RAM_DUMP_CHECKSUM_EN
      RUN:   if (final_pop) state_nx = CKSUM;
`else
      RUN:   if (final_pop) state_nx = FIN;
`endif
      CKSUM: if (m_ready) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum32;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sum32 <= '0;
    else if (state == IDLE && start) sum32 <= '0;
    else if (sk_pop)                 sum32 <= sum32 + sk_data;
  end

  // Skid is empty in CKSUM, so the checksum beat is driven directly.
  assign m_valid = sk_valid || (state == CKSUM);
  assign m_data  = (state == CKSUM) ? sum32 : sk_data;
  assign m_addr  = (state == CKSUM) ? '0 : sk_addr;
  assign m_last  = (state == CKSUM) ? 1'b1 : sk_last;
`else
  assign m_valid = sk_valid;
  assign m_data  = sk_data;
  assign m_addr  = sk_addr;
  assign m_last  = sk_last;
`endif
endmodule

// File: tb/tb_ram_dump_reader.sv
module tb_ram_dump_reader;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int D  = 64;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk, rst_n, we, start, busy, done, m_valid, m_ready, m_last;
  logic [AW-1:0] addr, m_addr;
  logic [DW-1:0] din, m_data;

  ram_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .din(din),
    .start(start), .busy(busy), .done(done), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int checks, errors;
  logic [DW-1:0] mdl [D];

  // One dump scenario: ready pattern (bit c%4 = m_ready in cycle c), an
  // optional write during the dump, an optional repeated start, an optional
  // reset at a beat, and the expected done cycle (-1 = not checked).
  typedef struct {
    logic [3:0]    pat;
    int            wc;
    int            wa;
    logic [DW-1:0] wd;
    logic          wnew;
    int            rs;
    int            abort_at;
    int            exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_dump(input int idx, input vec_t v, output logic [DW-1:0] last_data);
    logic [DW-1:0] snap [D];
    logic [DW-1:0] sum, ed;
    logic [38:0]   pbeat;
    logic          pstall, stop;
    int            nb, ndone, done_c, first_c, post;
    string         tag;
    tag = $sformatf("scen%0d", idx);
    for (int i = 0; i < D; i++) snap[i] = mdl[i];
    sum = '0; nb = 0; ndone = 0; done_c = -1; first_c = -1; post = -1;
    pstall = 1'b0; pbeat = '0; stop = 1'b0; last_data = '0;
    @(negedge clk); start = 1'b1; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3000 && !stop; c++) begin
      m_ready = v.pat[c % 4];
      we = (c == v.wc); addr = AW'(v.wa); din = v.wd;
      start = (c == v.rs);
      if (pstall)
        check({tag, " hold"}, {24'd0, m_valid, m_last, m_addr, m_data}, {24'd0, 1'b1, pbeat});
      if (done_c >= 0 && c > done_c)
        check({tag, " idle_after"}, {62'd0, m_valid, busy}, 64'd0);
      if (m_valid && m_ready) begin
        if (first_c < 0) first_c = c;
        if (nb < D) begin
          ed = (nb == v.wa && v.wnew) ? v.wd : snap[nb];
          if (nb == v.wa && v.wc >= 0 && !v.wnew) ed = snap[nb];
          sum += ed;
          check($sformatf("%s data%0d", tag, nb), m_data, ed);
          check($sformatf("%s addr%0d", tag, nb), m_addr, nb);
          check($sformatf("%s last%0d", tag, nb), m_last, (nb == D - 1) && (CK == 0));
        end else if (nb < D + CK) begin
          check({tag, " cksum"}, m_data, sum);
          check({tag, " cksum_addr"}, m_addr, 0);
          check({tag, " cksum_last"}, m_last, 1);
        end else begin
          check({tag, " extra_beat"}, nb, D + CK);
        end
        last_data = m_data;
        nb++;
      end
      pstall = m_valid && !m_ready;
      pbeat  = {m_last, m_addr, m_data};
      if (done) begin ndone++; done_c = c; if (post < 0) post = c + 8; end
      if (v.abort_at >= 0 && nb > v.abort_at) begin
        we = 1'b0; start = 1'b0; rst_n = 1'b0;
        #1;
        check({tag, " abort_valid"}, m_valid, 0);
        check({tag, " abort_busy"}, busy, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (done || m_valid || busy) ndone++;
        end
        check({tag, " abort_quiet"}, ndone, 0);
        stop = 1'b1;
      end
      if (c == post) stop = 1'b1;
      if (!stop) @(negedge clk);
    end
    we = 1'b0; start = 1'b0;
    if (v.abort_at < 0) begin
      check({tag, " beats"}, nb, D + CK);
      check({tag, " done_cnt"}, ndone, 1);
      if (v.exp_done >= 0) check({tag, " done_cyc"}, done_c, v.exp_done + CK);
      if (v.pat == 4'hF) check({tag, " first_cyc"}, first_c, 2);
    end
    if (v.wc >= 0) mdl[v.wa] = v.wd;
  endtask

  task automatic preload(input logic [DW-1:0] base, input logic [DW-1:0] step);
    for (int i = 0; i < D; i++) begin
      we = 1'b1; addr = AW'(i); din = base + step * i; mdl[i] = din;
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ld;
    clk = 1'b0; rst_n = 1'b0; we = 1'b0; addr = '0; din = '0;
    start = 1'b0; m_ready = 1'b0; checks = 0; errors = 0;

    //                pat      wc  wa  wd            new rs  abort done
    vecs[0] = '{4'hF,    -1, 0,  32'h0,        0,  -1, -1,   66};
    vecs[1] = '{4'b1001, -1, 0,  32'h0,        0,  -1, -1,   -1};
    vecs[2] = '{4'hF,    37, 40, 32'hDEADBEEF, 1,  -1, -1,   66};
    vecs[3] = '{4'hF,    11, 10, 32'h12345678, 0,  -1, -1,   66};
    vecs[4] = '{4'hF,    -1, 0,  32'h0,        0,  30, -1,   66};
    vecs[5] = '{4'hF,    -1, 0,  32'h0,        0,  -1, 20,   -1};
    vecs[6] = '{4'hF,    -1, 0,  32'h0,        0,  -1, -1,   66};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", m_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    preload(32'hA5000000, 32'd1);
    for (int s = 0; s < 7; s++) run_dump(s, vecs[s], ld);

`ifdef RAM_DUMP_CHECKSUM_EN
    // 64 * 0x04000000 = 2^32, wraps to zero.
    preload(32'h04000000, 32'd0);
    run_dump(7, vecs[0], ld);
    check("cksum_wrap", ld, 32'h00000000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
